// File: rtl/master_port.sv
// Bit-serial bus master: serialises one parallel request (address, then write data) LSB-first and deserialises read data.
// Optional read-wait watchdog enabled by defining MASTER_PORT_TIMEOUT_EN.
module master_port #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derr,
    output logic                  swdata,
    input  logic                  srdata,
    output logic                  smode,
    output logic                  mvalid,
    input  logic                  svalid,
    input  logic                  sready
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW) + 1;
    localparam logic [CW-1:0] ALAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DLAST = CW'(DATA_WIDTH - 1);

    if (ADDR_WIDTH < 1 || DATA_WIDTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("master_port: unsupported parameter values");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ADDR,
        WDATA,
        RWAIT,
        RDATA,
        DONE
    } state_t;

    state_t                state;
    logic                  mode;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] asr;
    logic [DATA_WIDTH-1:0] wsr;
    logic [DATA_WIDTH-2:0] rsr;
    logic [DATA_WIDTH-1:0] rnext;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wdog;
`endif

    // Incoming bit lands at the MSB; after DATA_WIDTH samples bit 0 has reached the LSB.
    assign rnext = {srdata, rsr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode   <= 1'b0;
            cnt    <= '0;
            asr    <= '0;
            wsr    <= '0;
            rsr    <= '0;
            dready <= 1'b1;
            ddone  <= 1'b0;
            derr   <= 1'b0;
            drdata <= '0;
            swdata <= 1'b0;
            smode  <= 1'b0;
            mvalid <= 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
            wdog   <= '0;
`endif
        end else begin
            ddone <= 1'b0;
            case (state)
                IDLE: begin
                    if (dvalid && dready) begin
                        mode   <= dmode;
                        asr    <= daddr;
                        wsr    <= dwdata;
                        dready <= 1'b0;
                        state  <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (sready) begin
                        mvalid <= 1'b1;
                        smode  <= mode;
                        swdata <= asr[0];
                        asr    <= {1'b0, asr[ADDR_WIDTH-1:1]};
                        cnt    <= '0;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (cnt == ALAST) begin
                        cnt <= '0;
                        if (mode) begin
                            swdata <= wsr[0];
                            wsr    <= {1'b0, wsr[DATA_WIDTH-1:1]};
                            state  <= WDATA;
                        end else begin
                            mvalid <= 1'b0;
                            swdata <= 1'b0;
                            state  <= RWAIT;
`ifdef MASTER_PORT_TIMEOUT_EN
                            wdog   <= '0;
`endif
                        end
                    end else begin
                        swdata <= asr[0];
                        asr    <= {1'b0, asr[ADDR_WIDTH-1:1]};
                        cnt    <= cnt + CW'(1);
                    end
                end
                WDATA: begin
                    if (cnt == DLAST) begin
                        mvalid <= 1'b0;
                        swdata <= 1'b0;
                        ddone  <= 1'b1;
                        derr   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        swdata <= wsr[0];
                        wsr    <= {1'b0, wsr[DATA_WIDTH-1:1]};
                        cnt    <= cnt + CW'(1);
                    end
                end
                RWAIT: begin
                    // The first svalid cycle already carries bit 0, so RDATA resumes counting at 1.
                    if (svalid) begin
                        rsr   <= rnext[DATA_WIDTH-1:1];
                        cnt   <= CW'(1);
                        state <= RDATA;
                    end
`ifdef MASTER_PORT_TIMEOUT_EN
                    else if (wdog == WLAST) begin
                        ddone  <= 1'b1;
                        derr   <= 1'b1;
                        drdata <= '0;
                        state  <= DONE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
`endif
                end
                RDATA: begin
                    if (svalid) begin
                        if (cnt == DLAST) begin
                            drdata <= rnext;
                            ddone  <= 1'b1;
                            derr   <= 1'b0;
                            state  <= DONE;
                        end else begin
                            rsr <= rnext[DATA_WIDTH-1:1];
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    dready <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_master_port.sv
// Self-checking bench for master_port: directed cases plus randomized transactions against a
// transaction-level model (expected serial stream, latency and returned data).
module tb_master_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          dvalid;
    logic          dready;
    logic          dmode;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic [DW-1:0] drdata;
    logic          ddone;
    logic          derr;
    logic          swdata;
    logic          srdata;
    logic          smode;
    logic          mvalid;
    logic          svalid;
    logic          sready;

    int            tests = 0;
    int            errors = 0;
    logic [DW-1:0] lastRead;

    master_port #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dvalid(dvalid),
        .dready(dready),
        .dmode(dmode),
        .daddr(daddr),
        .dwdata(dwdata),
        .drdata(drdata),
        .ddone(ddone),
        .derr(derr),
        .swdata(swdata),
        .srdata(srdata),
        .smode(smode),
        .mvalid(mvalid),
        .svalid(svalid),
        .sready(sready)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it when the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete transaction; the bench plays both the requesting device and the serial slave.
    task automatic applyStimulus(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic [DW-1:0] rd, input int rdyDelay, input int lat,
                                 input logic [31:0] vpat, input int vlen, input int gapPct);
        logic [31:0] obs;
        logic [31:0] expv;
        int          n;
        int          explen;
        int          bitIdx;
        int          step;
        logic        v;
        logic        waitBad;
        logic        modeBad;
        logic        earlyDone;

        obs       = '0;
        n         = 0;
        waitBad   = 1'b0;
        modeBad   = 1'b0;
        earlyDone = 1'b0;
        explen    = AW + (m ? DW : 0);
        expv      = 32'(a) | (m ? (32'(wd) << AW) : 32'd0);

        checkOutput("idle_dready", 32'(dready), 32'd1);
        dvalid = 1'b1;
        dmode  = m;
        daddr  = a;
        dwdata = wd;
        sready = (rdyDelay == 0);
        svalid = 1'b0;
        tick();
        dvalid = 1'b1;
        dmode  = ~m;
        daddr  = ~a;
        dwdata = ~wd;
        checkOutput("accept_dready", 32'(dready), 32'd0);
        if (mvalid !== 1'b0) waitBad = 1'b1;
        for (int i = 0; i < rdyDelay; i++) begin
            sready = 1'b0;
            tick();
            if (mvalid !== 1'b0 || dready !== 1'b0) waitBad = 1'b1;
        end
        checkOutput("wait_quiet", 32'(waitBad), 32'd0);

        for (int k = 0; k < 64; k++) begin
            sready = (k == 0) ? 1'b1 : 1'($urandom);
            svalid = 1'($urandom);
            srdata = 1'($urandom);
            tick();
            if (mvalid === 1'b1) begin
                if (n < 32) obs[n] = swdata;
                n++;
                if (smode !== m) modeBad = 1'b1;
                if (ddone !== 1'b0) earlyDone = 1'b1;
            end else begin
                break;
            end
        end
        svalid = 1'b0;
        sready = 1'b0;
        checkOutput("mvalid_len", 32'(n), 32'(explen));
        checkOutput("stream", obs, expv);
        checkOutput("smode", 32'(modeBad), 32'd0);
        checkOutput("swdata_idle", 32'(swdata), 32'd0);

        if (m) begin
            checkOutput("wr_ddone", 32'(ddone), 32'd1);
            checkOutput("wr_derr", 32'(derr), 32'd0);
            checkOutput("wr_drdata_held", 32'(drdata), 32'(lastRead));
        end else begin
            checkOutput("rd_no_early_done", 32'(ddone), 32'd0);
            for (int i = 0; i < lat; i++) begin
                svalid = 1'b0;
                srdata = 1'($urandom);
                tick();
                if (ddone !== 1'b0) earlyDone = 1'b1;
            end
            bitIdx = 0;
            step   = 0;
            while (bitIdx < DW && step < 64) begin
                if (vlen > 0) v = (step < vlen) ? vpat[step] : 1'b1;
                else          v = ($urandom_range(99) >= gapPct);
                svalid = v;
                srdata = v ? rd[bitIdx] : 1'($urandom);
                tick();
                if (v) bitIdx++;
                step++;
                if (bitIdx < DW && ddone !== 1'b0) earlyDone = 1'b1;
            end
            svalid = 1'b0;
            checkOutput("rd_ddone", 32'(ddone), 32'd1);
            checkOutput("rd_drdata", 32'(drdata), 32'(rd));
            checkOutput("rd_derr", 32'(derr), 32'd0);
            lastRead = rd;
        end
        checkOutput("early_done", 32'(earlyDone), 32'd0);

        tick();
        dvalid = 1'b0;
        checkOutput("ret_dready", 32'(dready), 32'd1);
        checkOutput("ret_ddone", 32'(ddone), 32'd0);
    endtask

    initial begin
        int w;
        int seen;

        rst      = 1'b1;
        dvalid   = 1'b0;
        dmode    = 1'b0;
        daddr    = '0;
        dwdata   = '0;
        srdata   = 1'b0;
        svalid   = 1'b0;
        sready   = 1'b0;
        lastRead = '0;
        repeat (2) tick();
        checkOutput("rst_dready", 32'(dready), 32'd1);
        checkOutput("rst_mvalid", 32'(mvalid), 32'd0);
        checkOutput("rst_ddone", 32'(ddone), 32'd0);
        checkOutput("rst_derr", 32'(derr), 32'd0);
        checkOutput("rst_drdata", 32'(drdata), 32'd0);
        checkOutput("rst_swdata", 32'(swdata), 32'd0);
        checkOutput("rst_smode", 32'(smode), 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(1'b1, 12'hA53, 8'h6C, 8'h00, 0, 0, 32'd0, 0, 0);
        applyStimulus(1'b0, 12'h005, 8'h00, 8'h3B, 0, 4, 32'd0, 0, 0);
        applyStimulus(1'b0, 12'($urandom), 8'h00, 8'hC5, 0, 0, 32'b11111011001, 11, 0);
        applyStimulus(1'b1, 12'($urandom), 8'($urandom), 8'h00, 10, 0, 32'd0, 0, 0);

        dvalid = 1'b1;
        dmode  = 1'b1;
        daddr  = 12'hFFF;
        dwdata = 8'hFF;
        sready = 1'b1;
        tick();
        dvalid = 1'b0;
        repeat (3) tick();
        checkOutput("pre_rst_mvalid", 32'(mvalid), 32'd1);
        checkOutput("pre_rst_swdata", 32'(swdata), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_mvalid", 32'(mvalid), 32'd0);
        checkOutput("async_rst_swdata", 32'(swdata), 32'd0);
        checkOutput("async_rst_ddone", 32'(ddone), 32'd0);
        checkOutput("async_rst_dready", 32'(dready), 32'd1);
        #2;
        rst    = 1'b0;
        sready = 1'b0;
        tick();
        lastRead = '0;
        applyStimulus(1'b1, 12'h3C9, 8'h5A, 8'h00, 1, 0, 32'd0, 0, 0);

        dvalid = 1'b1;
        dmode  = 1'b0;
        daddr  = 12'($urandom);
        sready = 1'b1;
        svalid = 1'b0;
        tick();
        dvalid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k > 0 && mvalid === 1'b0) break;
        end
        checkOutput("to_addr_end", 32'(mvalid), 32'd0);
`ifdef MASTER_PORT_TIMEOUT_EN
        for (w = 1; w <= 40; w++) begin
            tick();
            if (ddone === 1'b1) break;
        end
        checkOutput("to_cycles", 32'(w), 32'(TO));
        checkOutput("to_derr", 32'(derr), 32'd1);
        checkOutput("to_drdata", 32'(drdata), 32'd0);
        tick();
        checkOutput("to_ret_dready", 32'(dready), 32'd1);
        lastRead = '0;
`else
        w    = 0;
        seen = 0;
        repeat (1000) begin
            tick();
            if (ddone !== 1'b0) seen++;
        end
        checkOutput("no_timeout_done", 32'(seen), 32'd0);
        checkOutput("no_timeout_busy", 32'(dready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        lastRead = '0;
`endif

        for (int t = 0; t < 40; t++) begin
            applyStimulus(1'($urandom), 12'($urandom), 8'($urandom), 8'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 5), 32'd0, 0,
                          $urandom_range(0, 50));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/master_port.md
Name: master_port

Overview:
- Bit-serial bus master interface; sits directly upstream of a serial-bus slave (port plus memory), driving swdata/smode/mvalid and consuming srdata/svalid/sready.
- Accepts one parallel read/write request from a local device, serialises address then write data LSB-first, and for reads deserialises the returned data.
- One transaction in flight at a time. No arbitration or split support; the bus grant is taken as already held.

Parameters:
- ADDR_WIDTH, 12, address bits serialised per transaction.
- DATA_WIDTH, 8, data bits per transfer.
- TIMEOUT_CYCLES, 255, read-wait watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dvalid  in  1  device request valid.
- dready  out  1  block can accept a request.
- dmode  in  1  0 = read, 1 = write.
- daddr  in  ADDR_WIDTH  request address.
- dwdata  in  DATA_WIDTH  write data.
- drdata  out  DATA_WIDTH  read data, held until next completion.
- ddone  out  1  one-cycle completion pulse for reads and writes.
- derr  out  1  completion had an error; qualified by ddone.
- swdata  out  1  serial address/write data to slave.
- srdata  in  1  serial read data from slave.
- smode  out  1  0 = read, 1 = write, to slave.
- mvalid  out  1  swdata valid.
- svalid  in  1  srdata valid.
- sready  in  1  slave ready for a transaction.

Behaviour:
- All outputs are registered.
- Reset (any time, including mid-transaction):
  - state goes to IDLE; bit counter and shift registers clear.
  - dready=1; ddone=0; derr=0; drdata=0; swdata=0; smode=0; mvalid=0.
- State machine: IDLE, WAIT_RDY, ADDR, WDATA, RWAIT, RDATA, DONE.
- IDLE:
  - dready=1.
  - When dvalid&&dready at an edge, latch dmode/daddr/dwdata, set dready=0, go to WAIT_RDY.
  - dvalid in any other state is ignored.
- WAIT_RDY:
  - Hold until sready=1 is sampled.
  - On that edge: mvalid<=1, smode<=mode, swdata<=addr[0], counter=0, go to ADDR.
- ADDR:
  - Each edge shifts out the next address bit.
  - mvalid stays high for exactly ADDR_WIDTH cycles, bits addr[0]..addr[ADDR_WIDTH-1].
  - After the last address bit: write goes to WDATA with swdata<=wdata[0]; read goes to RWAIT with mvalid<=0.
- WDATA:
  - DATA_WIDTH cycles of wdata LSB-first; mvalid stays continuous from the first address bit to the last data bit (ADDR_WIDTH+DATA_WIDTH cycles).
  - Then mvalid<=0, go to DONE.
- RWAIT:
  - mvalid=0; wait for svalid.
  - A cycle with svalid=1 carries data bit 0: sample it and go to RDATA.
- RDATA:
  - Sample srdata into bit position counter on each edge where svalid=1.
  - Cycles with svalid=0 are stalls: no shift, no count.
  - After DATA_WIDTH bits, go to DONE.
- DONE:
  - ddone=1 for one cycle.
  - Reads update drdata in the same edge; writes leave drdata unchanged.
  - Then go to IDLE with dready=1.
  - Next request can be accepted the cycle after ddone.
- Write latency from the accept edge with sready already 1: mvalid high cycles 1..ADDR_WIDTH+DATA_WIDTH, ddone at cycle ADDR_WIDTH+DATA_WIDTH+1.
- sready dropping after ADDR is entered is ignored.
- svalid during ADDR/WDATA is ignored.
- swdata=0 whenever mvalid=0.
- Counter width is clog2(max(ADDR_WIDTH, DATA_WIDTH))+1.
- Counter does not wrap: terminal compare is equality with width-1.

Optional Feature:
- Macro: MASTER_PORT_TIMEOUT_EN.
- Defined: a watchdog counts cycles spent in RWAIT.
  - Reaching TIMEOUT_CYCLES with no svalid goes to DONE with derr=1 and drdata=0.
  - The counter clears on entering RWAIT.
- Undefined: no watchdog; RWAIT waits indefinitely; derr is tied to 0.

Test Plan:
- Write daddr=0xA53, dwdata=0x6C, sready=1 -> mvalid high 20 cycles, smode=1; swdata bits 1,1,0,0,1,0,1,0,0,1,0,1 then 0,0,1,1,0,1,1,0; ddone on cycle 21; derr=0.
- Read daddr=0x005; slave returns svalid 8 cycles, srdata=0x3B LSB-first, 4 cycles after the last address bit -> smode=0, mvalid high 12 cycles; drdata=0x3B with ddone.
- Read with svalid gaps (pattern 1,0,0,1,1,0,1,1,1,1,1) returning 0xC5 -> drdata=0xC5; stalls not counted.
- sready=0 for 10 cycles after accept -> mvalid stays 0 and dready stays 0; transfer starts the edge after sready rises; second dvalid during busy is ignored.
- rst pulsed in the middle of ADDR -> mvalid, swdata, and ddone go to 0 immediately (async) and dready goes to 1; a fresh write afterwards completes correctly.
- With MASTER_PORT_TIMEOUT_EN and TIMEOUT_CYCLES=16: read with svalid never asserted -> ddone with derr=1 and drdata=0 at 16 cycles in RWAIT. Without the macro: no ddone after 1000 cycles.
